// File: rtl/secded_scrubber.sv
// Background SEC-DED scrubber: walks all words, corrects single-bit errors in place and
// counts corrected/uncorrectable words. Define SCRUB_WRITEBACK_EN to build write-back.
module secded_scrubber #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DEPTH  = 2 ** ADDR_W,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              host_req,
   input  logic [12:0]       mem_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr_en,
   output logic [12:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  corr_cnt,
   output logic [CNT_W-1:0]  uncorr_cnt,
   output logic [ADDR_W-1:0] last_bad_addr
);

   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  CntMax   = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StCheck,
`ifdef SCRUB_WRITEBACK_EN
      StWrite,
`endif
      StDone
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [12:0]         cw_q, cw_d;
   logic [CNT_W-1:0]    corr_cnt_q, corr_cnt_d;
   logic [CNT_W-1:0]    uncorr_cnt_q, uncorr_cnt_d;
   logic [ADDR_W-1:0]   last_bad_addr_q, last_bad_addr_d;

   logic [3:0] syn;
   logic       par;
   logic       is_clean;
   logic       is_corr;
   logic       adv;

   // Syndrome is the XOR of the positions of all set bits in cw_q[12:1].
   always_comb begin
      syn = 4'd0;
      for (int i = 1; i < 13; i++) begin
         if (cw_q[i]) begin
            syn = syn ^ 4'(i);
         end
      end
      par      = ^cw_q;
      is_clean = (syn == 4'd0) && !par;
      is_corr  = par && (syn <= 4'd12);
   end

`ifdef SCRUB_WRITEBACK_EN
   logic [12:0] cw_fix;

   always_comb begin
      cw_fix = cw_q;
      if (par && (syn == 4'd0)) begin
         cw_fix[0] = ~cw_q[0];
      end else if (par && (syn <= 4'd12)) begin
         cw_fix[syn] = ~cw_q[syn];
      end
   end
`endif

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      cw_d            = cw_q;
      corr_cnt_d      = corr_cnt_q;
      uncorr_cnt_d    = uncorr_cnt_q;
      last_bad_addr_d = last_bad_addr_q;
      adv             = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               addr_d       = '0;
               corr_cnt_d   = '0;
               uncorr_cnt_d = '0;
               state_d      = StRead;
            end
         end
         StRead: begin
            if (!host_req) begin
               cw_d    = mem_rdata;
               state_d = StCheck;
            end
         end
         StCheck: begin
            if (is_clean) begin
               adv = 1'b1;
            end else if (is_corr) begin
               if (corr_cnt_q != CntMax) begin
                  corr_cnt_d = corr_cnt_q + CNT_W'(1);
               end
`ifdef SCRUB_WRITEBACK_EN
               state_d = StWrite;
`else
               adv = 1'b1;
`endif
            end else begin
               if (uncorr_cnt_q != CntMax) begin
                  uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
               end
               last_bad_addr_d = addr_q;
               adv             = 1'b1;
            end
         end
`ifdef SCRUB_WRITEBACK_EN
         StWrite: begin
            if (!host_req) begin
               adv = 1'b1;
            end
         end
`endif
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // No wrap within a pass: the last address finishes the pass.
      if (adv) begin
         if (addr_q == LastAddr) begin
            state_d = StDone;
         end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = StRead;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= StIdle;
         addr_q          <= '0;
         cw_q            <= '0;
         corr_cnt_q      <= '0;
         uncorr_cnt_q    <= '0;
         last_bad_addr_q <= '0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         cw_q            <= cw_d;
         corr_cnt_q      <= corr_cnt_d;
         uncorr_cnt_q    <= uncorr_cnt_d;
         last_bad_addr_q <= last_bad_addr_d;
      end
   end

   // Write strobe is decoded from state so it drops asynchronously with reset.
   always_comb begin
`ifdef SCRUB_WRITEBACK_EN
      mem_wr_en = (state_q == StWrite) && !host_req;
      mem_wdata = (state_q == StWrite) ? cw_fix : 13'h0000;
`else
      mem_wr_en = 1'b0;
      mem_wdata = 13'h0000;
`endif
      mem_addr      = addr_q;
      busy          = (state_q != StIdle);
      done          = (state_q == StDone);
      corr_cnt      = corr_cnt_q;
      uncorr_cnt    = uncorr_cnt_q;
      last_bad_addr = last_bad_addr_q;
   end

endmodule

// File: tb/tb_secded_scrubber.sv
// Directed bench for secded_scrubber with a combinational-read memory model.
module tb_secded_scrubber;

`ifdef SCRUB_WRITEBACK_EN
   localparam bit Wb = 1'b1;
`else
   localparam bit Wb = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        host_req;
   logic [12:0] mem_rdata;
   logic [3:0]  mem_addr;
   logic        mem_wr_en;
   logic [12:0] mem_wdata;
   logic        busy;
   logic        done;
   logic [7:0]  corr_cnt;
   logic [7:0]  uncorr_cnt;
   logic [3:0]  last_bad_addr;

   logic [12:0] mem [16];
   int          checks = 0;
   int          errors = 0;
   int          wr_cnt = 0;
   int          viol = 0;
   logic [3:0]  wr_addr;
   logic [12:0] wr_data;
   logic [3:0]  c1_addr;
   int          cyc;

   secded_scrubber dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .host_req     (host_req),
      .mem_rdata    (mem_rdata),
      .mem_addr     (mem_addr),
      .mem_wr_en    (mem_wr_en),
      .mem_wdata    (mem_wdata),
      .busy         (busy),
      .done         (done),
      .corr_cnt     (corr_cnt),
      .uncorr_cnt   (uncorr_cnt),
      .last_bad_addr(last_bad_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_wr_en) begin
         wr_cnt++;
         wr_addr = mem_addr;
         wr_data = mem_wdata;
         mem[mem_addr] = mem_wdata;
      end
   end

   always @(negedge clk) begin
      if (mem_wr_en && host_req) viol++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 16; i++) mem[i] = 13'h0000;
      wr_cnt = 0;
      viol   = 0;
   endtask

   // Cycle 1 is the cycle after the edge that accepts start; returns the cycle done is seen.
   task automatic run_pass(input int hold_from, input int start_at, input int rst_at,
                           output int n);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n = 1;
      while (n < 200) begin
         host_req = (n >= hold_from) && (n < hold_from + 3);
         start    = (n == start_at);
         if (n == 1) c1_addr = mem_addr;
         if (n == rst_at) begin
            rst_n = 1'b0;
            #1;
            break;
         end
         if (done) break;
         @(posedge clk);
         #1;
         n++;
      end
      host_req = 1'b0;
      start    = 1'b0;
      check("pass_bounded", 32'(n < 200), 32'd1);
   endtask

   task automatic after_done();
      @(posedge clk);
      #1;
      check("done_one_cycle", 32'(done), 32'd0);
      check("busy_dropped", 32'(busy), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_wr_en"}, 32'(mem_wr_en), 32'd0);
      check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
      check({tag, "_addr"}, 32'(mem_addr), 32'd0);
      check({tag, "_corr"}, 32'(corr_cnt), 32'd0);
      check({tag, "_uncorr"}, 32'(uncorr_cnt), 32'd0);
      check({tag, "_lastbad"}, 32'(last_bad_addr), 32'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      host_req = 1'b0;
      clear_mem();
      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Clean memory
      clear_mem();
      run_pass(1000, 1000, 1000, cyc);
      check("clean_done_cycle", 32'(cyc), 32'd33);
      check("clean_corr", 32'(corr_cnt), 32'd0);
      check("clean_uncorr", 32'(uncorr_cnt), 32'd0);
      check("clean_writes", 32'(wr_cnt), 32'd0);
      after_done();

      // Single error at position 5
      clear_mem();
      mem[5] = 13'h0020;
      run_pass(1000, 1000, 1000, cyc);
      check("sec5_done_cycle", 32'(cyc), Wb ? 32'd34 : 32'd33);
      check("sec5_corr", 32'(corr_cnt), 32'd1);
      check("sec5_uncorr", 32'(uncorr_cnt), 32'd0);
      check("sec5_writes", 32'(wr_cnt), Wb ? 32'd1 : 32'd0);
      if (Wb) begin
         check("sec5_wr_addr", 32'(wr_addr), 32'd5);
         check("sec5_wr_data", 32'(wr_data), 32'h0000);
      end
      check("sec5_mem", 32'(mem[5]), Wb ? 32'h0000 : 32'h0020);
      after_done();

      // Error in the overall parity bit
      clear_mem();
      mem[9] = 13'h0001;
      run_pass(1000, 1000, 1000, cyc);
      check("par9_corr", 32'(corr_cnt), 32'd1);
      check("par9_writes", 32'(wr_cnt), Wb ? 32'd1 : 32'd0);
      if (Wb) begin
         check("par9_wr_addr", 32'(wr_addr), 32'd9);
         check("par9_wr_data", 32'(wr_data), 32'h0000);
      end
      after_done();

      // Double error: syndrome 1, parity even
      clear_mem();
      mem[12] = 13'h0030;
      run_pass(1000, 1000, 1000, cyc);
      check("ded12_done_cycle", 32'(cyc), 32'd33);
      check("ded12_corr", 32'(corr_cnt), 32'd0);
      check("ded12_uncorr", 32'(uncorr_cnt), 32'd1);
      check("ded12_lastbad", 32'(last_bad_addr), 32'd12);
      check("ded12_writes", 32'(wr_cnt), 32'd0);
      check("ded12_mem", 32'(mem[12]), 32'h0030);
      after_done();

      // Host holds the port for 3 cycles where word 5 would be written; start while busy
      clear_mem();
      mem[5] = 13'h0020;
      run_pass(13, 20, 1000, cyc);
      check("hold_done_cycle", 32'(cyc), Wb ? 32'd37 : 32'd36);
      check("hold_corr", 32'(corr_cnt), 32'd1);
      check("hold_writes", 32'(wr_cnt), Wb ? 32'd1 : 32'd0);
      check("hold_no_wr_under_host", 32'(viol), 32'd0);
      check("hold_lastbad_kept", 32'(last_bad_addr), 32'd12);
      if (Wb) check("hold_wr_addr", 32'(wr_addr), 32'd5);
      after_done();

      // Reset while checking a correctable word
      clear_mem();
      mem[5] = 13'h0020;
      run_pass(1000, 1000, 12, cyc);
      check("rst_cycle", 32'(cyc), 32'd12);
      check_reset_outputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst_no_write", 32'(wr_cnt), 32'd0);
      check("midrst_mem", 32'(mem[5]), 32'h0020);
      run_pass(1000, 1000, 1000, cyc);
      check("rerun_first_addr", 32'(c1_addr), 32'd0);
      check("rerun_done_cycle", 32'(cyc), Wb ? 32'd34 : 32'd33);
      check("rerun_corr", 32'(corr_cnt), 32'd1);
      check("rerun_writes", 32'(wr_cnt), Wb ? 32'd1 : 32'd0);
      after_done();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
